// File: rtl/panel_input_conditioner.sv
// Board KEY/SW input conditioning: 2-FF synchroniser, counter debouncer, key press/release strobes.
// Optional key auto-repeat is enabled by defining PANEL_AUTOREPEAT_EN.
module panel_input_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int NUM_SW          = 18,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic [NUM_SW-1:0]   sw_raw,
  output logic [NUM_KEYS-1:0] key_pressed,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_SW-1:0]   sw_stable,
  output logic                sw_changed
);

  // Keys and switches share one channel vector: keys in the low bits, idle-high.
  localparam int N = NUM_KEYS + NUM_SW;
  localparam logic [N-1:0] RST_LVL = {{NUM_SW{1'b0}}, {NUM_KEYS{1'b1}}};
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES);
  localparam bit CFG_OK = (DEBOUNCE_CYCLES >= 1) && (DEBOUNCE_CYCLES < (2 ** CNT_W)) &&
                          (REPEAT_PERIOD >= 1) && (REPEAT_DELAY >= REPEAT_PERIOD);

  if (!CFG_OK) begin : g_cfg_check
    $error("panel_input_conditioner: inconsistent debounce/repeat parameters");
  end

  typedef enum logic {IDLE, COUNTING} state_t;

  state_t           state     [N];
  state_t           state_nxt [N];
  logic [CNT_W-1:0] cnt       [N];
  logic [CNT_W-1:0] cnt_nxt   [N];
  logic [N-1:0]     raw, sync_p0, sync_p1, stable, stable_nxt, fell, rose;
  logic [NUM_KEYS-1:0] rep_hit;

  assign raw = {sw_raw, key_raw};

  // Stage p0/p1: synchroniser; then debounce state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0 <= RST_LVL;
      sync_p1 <= RST_LVL;
      stable  <= RST_LVL;
      for (int i = 0; i < N; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      stable  <= stable_nxt;
      for (int i = 0; i < N; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < N; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      case (state[i])
        IDLE: begin
          cnt_nxt[i] = '0;
          if (sync_p1[i] != stable[i]) begin
            state_nxt[i] = COUNTING;
            cnt_nxt[i]   = CNT_W'(1);
          end
        end
        COUNTING: begin
          if (sync_p1[i] == stable[i]) begin
            state_nxt[i] = IDLE;
            cnt_nxt[i]   = '0;
          end else if (cnt[i] == DB_LAST) begin
            stable_nxt[i] = sync_p1[i];
            state_nxt[i]  = IDLE;
            cnt_nxt[i]    = '0;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign fell = stable & ~stable_nxt;
  assign rose = ~stable & stable_nxt;

`ifdef PANEL_AUTOREPEAT_EN
  // Counter runs from the press pulse; after the first repeat it reloads so later hits are one period apart.
  localparam int REP_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [REP_W-1:0] REP_HIT    = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [REP_W-1:0] rep_cnt [NUM_KEYS];

  always_comb begin
    rep_hit = '0;
    for (int k = 0; k < NUM_KEYS; k++)
      rep_hit[k] = ~stable[k] & ~stable_nxt[k] & (rep_cnt[k] == REP_HIT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_KEYS; k++) rep_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (stable[k])       rep_cnt[k] <= '0;
        else if (rep_hit[k]) rep_cnt[k] <= REP_RELOAD;
        else                 rep_cnt[k] <= rep_cnt[k] + REP_W'(1);
      end
    end
  end
`else
  assign rep_hit = '0;
`endif

  // Stage p2: strobes registered on the same edge that updates the stable level
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_press   <= '0;
      key_release <= '0;
      sw_changed  <= 1'b0;
    end else begin
      key_press   <= fell[NUM_KEYS-1:0] | rep_hit;
      key_release <= rose[NUM_KEYS-1:0];
      sw_changed  <= |(fell[N-1:NUM_KEYS] | rose[N-1:NUM_KEYS]);
    end
  end

  assign key_pressed = ~stable[NUM_KEYS-1:0];
  assign sw_stable   = stable[N-1:NUM_KEYS];

endmodule

// File: tb/tb_panel_input_conditioner.sv
// Directed bench for panel_input_conditioner: vector table of held input levels plus
// cycle-exact sequences for latency, alignment, simultaneity, reset and auto-repeat.
module tb_panel_input_conditioner;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  key_raw = 4'hF;
  logic [17:0] sw_raw = '0;
  logic [3:0]  key_pressed, key_press, key_release;
  logic [17:0] sw_stable;
  logic        sw_changed;

`ifdef PANEL_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  panel_input_conditioner #(
    .NUM_KEYS(4), .NUM_SW(18), .DEBOUNCE_CYCLES(8), .CNT_W(5),
    .REPEAT_DELAY(20), .REPEAT_PERIOD(6)
  ) dut (
    .clock(clock), .reset(reset), .key_raw(key_raw), .sw_raw(sw_raw),
    .key_pressed(key_pressed), .key_press(key_press), .key_release(key_release),
    .sw_stable(sw_stable), .sw_changed(sw_changed)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0]  key;
    logic [17:0] sw;
    int          cyc;
    logic [3:0]  exp_pressed;
    logic [17:0] exp_sw;
    logic [15:0] exp_press;   // pulse count per key, one nibble per key
    logic [15:0] exp_rel;
    int          exp_chg;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] k, input logic [17:0] s);
    @(negedge clock);
    key_raw = k;
    sw_raw  = s;
  endtask

  initial begin
    int press_cnt [4];
    int rel_cnt [4];
    int chg_cnt;
    logic [15:0] pp, rp;
    logic [3:0]  ek;

    tbl[0]  = '{4'hF, 18'h00000,  5, 4'h0, 18'h00000, 16'h0000, 16'h0000, 0};
    tbl[1]  = '{4'hE, 18'h00000,  5, 4'h0, 18'h00000, 16'h0000, 16'h0000, 0};
    tbl[2]  = '{4'hF, 18'h00000,  3, 4'h0, 18'h00000, 16'h0000, 16'h0000, 0};
    tbl[3]  = '{4'hE, 18'h00000,  5, 4'h0, 18'h00000, 16'h0000, 16'h0000, 0};
    tbl[4]  = '{4'hF, 18'h00000, 15, 4'h0, 18'h00000, 16'h0000, 16'h0000, 0};
    tbl[5]  = '{4'hE, 18'h00000, 12, 4'h1, 18'h00000, 16'h0001, 16'h0000, 0};
    tbl[6]  = '{4'hF, 18'h00000, 12, 4'h0, 18'h00000, 16'h0000, 16'h0001, 0};
    tbl[7]  = '{4'hF, 18'h00013, 12, 4'h0, 18'h00013, 16'h0000, 16'h0000, 1};
    tbl[8]  = '{4'hF, 18'h3FFFF,  4, 4'h0, 18'h00013, 16'h0000, 16'h0000, 0};
    tbl[9]  = '{4'hF, 18'h00013, 15, 4'h0, 18'h00013, 16'h0000, 16'h0000, 0};
    tbl[10] = '{4'h5, 18'h3FFFF, 12, 4'hA, 18'h3FFFF, 16'h1010, 16'h0000, 1};
    tbl[11] = '{4'hF, 18'h00000, 12, 4'h0, 18'h00000, 16'h0000, 16'h1010, 1};

    // Reset state with all keys released
    repeat (3) tick();
    check("reset key_pressed", key_pressed, 4'h0);
    check("reset key_press", key_press, 4'h0);
    check("reset key_release", key_release, 4'h0);
    check("reset sw_stable", sw_stable, 18'h0);
    check("reset sw_changed", sw_changed, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].key, tbl[i].sw);
      for (int k = 0; k < 4; k++) begin press_cnt[k] = 0; rel_cnt[k] = 0; end
      chg_cnt = 0;
      for (int c = 0; c < tbl[i].cyc; c++) begin
        tick();
        for (int k = 0; k < 4; k++) begin
          press_cnt[k] += int'(key_press[k]);
          rel_cnt[k]   += int'(key_release[k]);
        end
        chg_cnt += int'(sw_changed);
      end
      for (int k = 0; k < 4; k++) begin
        pp[k*4 +: 4] = press_cnt[k][3:0];
        rp[k*4 +: 4] = rel_cnt[k][3:0];
      end
      check($sformatf("vec%0d key_pressed", i), key_pressed, tbl[i].exp_pressed);
      check($sformatf("vec%0d sw_stable", i), sw_stable, tbl[i].exp_sw);
      check($sformatf("vec%0d press_count", i), pp, tbl[i].exp_press);
      check($sformatf("vec%0d release_count", i), rp, tbl[i].exp_rel);
      check($sformatf("vec%0d sw_changed_count", i), chg_cnt, tbl[i].exp_chg);
    end

    // Edge captured at cycle 1; the accepted level and strobe appear 10 cycles later, at cycle 11
    drive(4'hB, 18'h0);
    for (int j = 1; j <= 30; j++) begin
      tick();
      check($sformatf("k2 press c%0d", j), key_press, (j == 11) ? 4'b0100 : 4'b0000);
    end
    check("k2 held key_pressed", key_pressed, 4'b0100);
    drive(4'hF, 18'h0);
    for (int j = 1; j <= 14; j++) begin
      tick();
      check($sformatf("k2 release c%0d", j), key_release, (j == 11) ? 4'b0100 : 4'b0000);
    end
    check("k2 released key_pressed", key_pressed, 4'b0000);

    // sw_changed coincides with the sw_stable update
    drive(4'hF, 18'h13);
    for (int j = 1; j <= 14; j++) begin
      tick();
      check($sformatf("sw align c%0d", j), {sw_changed, sw_stable},
            {(j == 11), (j >= 11) ? 18'h13 : 18'h0});
    end

    drive(4'h5, 18'h13);
    for (int j = 1; j <= 14; j++) begin
      tick();
      check($sformatf("k1k3 press c%0d", j), key_press, (j == 11) ? 4'b1010 : 4'b0000);
    end
    drive(4'hF, 18'h13);
    repeat (14) tick();

    // Hold key 1: initial pulse, then repeats at +20 and every 6 after when enabled
    drive(4'hD, 18'h13);
    for (int j = 1; j <= 50; j++) begin
      tick();
      ek = ((j == 11) || (AR && j >= 31 && ((j - 31) % 6) == 0)) ? 4'b0010 : 4'b0000;
      check($sformatf("k1 repeat c%0d", j), key_press, ek);
    end
    drive(4'hF, 18'h13);
    repeat (14) tick();
    check("k1 released key_pressed", key_pressed, 4'b0000);

    // Asynchronous reset between clock edges
    drive(4'hB, 18'h13);
    repeat (12) tick();
    check("pre-reset key_pressed", key_pressed, 4'b0100);
    check("pre-reset sw_stable", sw_stable, 18'h13);
    #1;
    reset = 1'b0;
    #1;
    check("async reset key_pressed", key_pressed, 4'b0000);
    check("async reset sw_stable", sw_stable, 18'h0);

    // Key 3 held low and switch 0 high through reset release
    key_raw = 4'h7;
    sw_raw  = 18'h1;
    repeat (2) tick();
    @(negedge clock);
    reset = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      tick();
      check($sformatf("held-thru-reset c%0d", j), {sw_changed, key_press},
            {(j == 11), (j == 11) ? 4'b1000 : 4'b0000});
    end
    check("held-thru-reset sw_stable", sw_stable, 18'h1);

    // Reset mid-debounce discards the pending press
    drive(4'hF, 18'h1);
    repeat (14) tick();
    drive(4'hE, 18'h1);
    repeat (6) tick();
    reset   = 1'b0;
    key_raw = 4'hF;
    repeat (2) tick();
    @(negedge clock);
    reset = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      tick();
      check($sformatf("mid-debounce reset c%0d", j), key_press, 4'b0000);
    end
    check("mid-debounce key_pressed", key_pressed, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
